// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD controller and its command host: command codes,
// host FSM encoding and snoop counter widths.
package lcd_pkg;

  typedef enum logic [3:0] {
    CmdWrite = 4'd0,
    CmdUp    = 4'd1,
    CmdDown  = 4'd2,
    CmdLeft  = 4'd3,
    CmdRight = 4'd4,
    CmdMax   = 4'd5,
    CmdMin   = 4'd6,
    CmdAvg   = 4'd7
  } lcd_cmd_e;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StLatch,
    StWaitRdy,
    StIssue,
    StHold,
    StWaitDone,
    StFin,
    StErr
  } host_state_e;

  localparam int unsigned ChkW = 14;
  localparam int unsigned CntW = 7;

  // Codes 8..15 are undefined and get skipped by the host.
  function automatic logic is_valid_cmd(input logic [3:0] code);
    return !code[3];
  endfunction

endpackage

// File: rtl/lcd_iram_snoop.sv
// Passive IRAM write monitor: accumulates a wrapping checksum of written bytes and a
// saturating write count.
module lcd_iram_snoop
  import lcd_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic            iram_ceb,
  input  logic            iram_web,
  input  logic [7:0]      iram_d,
  output logic [ChkW-1:0] checksum,
  output logic [CntW-1:0] wr_count
);

  logic [ChkW-1:0] sum_q;
  logic [CntW-1:0] cnt_q;
  logic            hit;

  assign hit = en && iram_ceb && !iram_web;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else if (hit) begin
      sum_q <= sum_q + ChkW'(iram_d);
      if (cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign checksum = sum_q;
  assign wr_count = cnt_q;

endmodule

// File: rtl/lcd_cmd_host.sv
// LCD command host: walks the command ROM, issues each valid command to the controller
// while honouring busy, then waits for done and reports snooped IRAM write statistics.
module lcd_cmd_host
  import lcd_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              CROM_rd,
  output logic [ADDR_W-1:0] CROM_A,
  input  logic [3:0]        CROM_Q,
  output logic [3:0]        cmd,
  output logic              cmd_valid,
  input  logic              busy,
  input  logic              done,
  input  logic              IRAM_ceb,
  input  logic              IRAM_web,
  input  logic [7:0]        IRAM_D,
  output logic              finished,
  output logic              err,
  output logic [ChkW-1:0]   checksum,
  output logic [CntW-1:0]   wr_count
);

  // Pointer has one extra bit so it can reach CMD_DEPTH when the list is exhausted.
  localparam int unsigned     PtrW    = ADDR_W + 1;
  localparam int unsigned     TmoW    = $clog2(TIMEOUT + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(CMD_DEPTH - 1);
  localparam logic [PtrW-1:0] PtrEnd  = PtrW'(CMD_DEPTH);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  host_state_e     state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [3:0]      cmd_q, cmd_d;
  logic            snoop_clr;
  logic            snoop_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      tmo_q   <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tmo_q   <= tmo_d;
      cmd_q   <= cmd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    tmo_d     = tmo_q;
    cmd_d     = cmd_q;
    snoop_clr = 1'b0;
    unique case (state_q)
      StIdle, StFin, StErr: begin
        if (start) begin
          state_d   = StFetch;
          ptr_d     = '0;
          snoop_clr = 1'b1;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        cmd_d = CROM_Q;
        ptr_d = ptr_q + 1'b1;
        if (!is_valid_cmd(CROM_Q)) begin
          state_d = (ptr_q == PtrLast) ? StErr : StFetch;
        end else begin
          state_d = StWaitRdy;
        end
      end
      StWaitRdy: begin
        if (!busy) begin
          state_d = StIssue;
          tmo_d   = '0;
        end else if (tmo_q == TmoLast) begin
          state_d = StErr;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StIssue: begin
        if (cmd_q == CmdWrite) begin
          state_d = StWaitDone;
        end else if (ptr_q == PtrEnd) begin
          state_d = StErr;
        end else begin
          state_d = StHold;
        end
      end
      // Controller raises busy only the cycle after the strobe, so skip one cycle here.
      StHold: state_d = StFetch;
      StWaitDone: begin
        if (done) begin
          state_d = StFin;
          tmo_d   = '0;
        end else if (tmo_q == TmoLast) begin
          state_d = StErr;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign snoop_en  = !(state_q inside {StIdle, StFin, StErr});
  assign CROM_rd   = (state_q == StFetch);
  assign CROM_A    = ptr_q[ADDR_W-1:0];
  assign cmd_valid = (state_q == StIssue);
  assign cmd       = cmd_q;
  assign finished  = (state_q == StFin);
  assign err       = (state_q == StErr);

  lcd_iram_snoop u_snoop (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (snoop_clr),
    .en       (snoop_en),
    .iram_ceb (IRAM_ceb),
    .iram_web (IRAM_web),
    .iram_d   (IRAM_D),
    .checksum (checksum),
    .wr_count (wr_count)
  );

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Bench for lcd_cmd_host: ROM and controller models, directed plus randomized runs checked
// against a list-level reference model.
module tb_lcd_cmd_host;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        start_c = 1'b0;
  logic        CROM_rd;
  logic [4:0]  CROM_A;
  logic [3:0]  CROM_Q = 4'd0;
  logic [3:0]  cmd;
  logic        cmd_valid;
  logic        busy = 1'b1;
  logic        done = 1'b0;
  logic        IRAM_ceb = 1'b0;
  logic        IRAM_web = 1'b1;
  logic [7:0]  IRAM_D = 8'd0;
  logic        finished;
  logic        err;
  logic [13:0] checksum;
  logic [6:0]  wr_count;

  assign start = start_a | start_b | start_c;

  lcd_cmd_host dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .CROM_rd   (CROM_rd),
    .CROM_A    (CROM_A),
    .CROM_Q    (CROM_Q),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .busy      (busy),
    .done      (done),
    .IRAM_ceb  (IRAM_ceb),
    .IRAM_web  (IRAM_web),
    .IRAM_D    (IRAM_D),
    .finished  (finished),
    .err       (err),
    .checksum  (checksum),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  // Stimulus configuration, written only by the main initial block.
  logic [3:0] rom [32];
  logic [7:0] wdata [256];
  int         init_busy = 0;
  int         op_len = 1;
  int         nw = 0;
  bit         stuck_busy = 1'b0;
  bit         start_with_done = 1'b0;

  // Controller model state, written only by the negedge block.
  logic [3:0] issued [$];
  int         busy_left = 0;
  int         wr_idx = 0;
  bit         wr_active = 1'b0;
  bit         prev_cv = 1'b0;
  int         busy_viol = 0;
  int         dbl_viol = 0;
  int         done_cyc = 0;
  logic       fin_at_done = 1'b0;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (CROM_rd) CROM_Q <= rom[CROM_A];

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 1'b1; done = 1'b0; start_b = 1'b0; IRAM_ceb = 1'b0; IRAM_web = 1'b1;
      wr_active = 1'b0; busy_left = 0; prev_cv = 1'b0;
    end else begin
      if (start_a) begin
        issued.delete(); busy_left = init_busy; busy_viol = 0; dbl_viol = 0;
      end
      if (cmd_valid) begin
        issued.push_back(cmd);
        if (busy) busy_viol++;
        if (prev_cv) dbl_viol++;
      end
      prev_cv = cmd_valid;
      done = 1'b0; start_b = 1'b0; IRAM_ceb = 1'b0; IRAM_web = 1'b1; IRAM_D = 8'($urandom);
      if (cmd_valid) begin
        busy = 1'b1;
        if (cmd == 4'd0) begin
          wr_active = 1'b1; wr_idx = 0;
        end else begin
          busy_left = op_len - 1;
        end
      end else if (wr_active) begin
        if (wr_idx < nw) begin
          case ($urandom_range(0, 5))
            0: ;
            1: IRAM_ceb = 1'b1;
            2: IRAM_web = 1'b0;
            default: begin
              IRAM_ceb = 1'b1; IRAM_web = 1'b0; IRAM_D = wdata[wr_idx]; wr_idx++;
            end
          endcase
        end else begin
          wr_active = 1'b0; busy = 1'b0; done = 1'b1; done_cyc = cyc;
          fin_at_done = finished; start_b = start_with_done;
        end
      end else if (busy_left > 0) begin
        busy = 1'b1; busy_left--;
      end else begin
        busy = stuck_busy;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_run(input string tag);
    tick(); start_a = 1'b1;
    tick();
    check({tag, ":crom_rd0"}, 32'(CROM_rd), 1);
    check({tag, ":crom_a0"}, 32'(CROM_A), 0);
    check({tag, ":err_clr"}, 32'(err), 0);
    check({tag, ":fin_clr"}, 32'(finished), 0);
    check({tag, ":chk_clr"}, 32'(checksum), 0);
    start_a = 1'b0;
  endtask

  task automatic wait_end(output int end_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      tick();
      if (finished || err) begin
        timed_out = 1'b0;
        break;
      end
    end
    end_cyc = cyc;
  endtask

  // Reference: valid codes are issued in ROM order up to and including the first WRITE;
  // no WRITE in the list means an error and no snooped writes.
  task automatic check_run(input string tag, input int end_cyc, input bit timed_out);
    logic [3:0] exp_q [$];
    bit exp_err;
    int sum;
    exp_err = 1'b1;
    sum = 0;
    for (int i = 0; i < 32; i++) begin
      if (rom[i] < 4'd8) exp_q.push_back(rom[i]);
      if (rom[i] == 4'd0) begin
        exp_err = 1'b0;
        break;
      end
    end
    if (!exp_err) for (int i = 0; i < nw; i++) sum += int'(wdata[i]);
    check({tag, ":timeout"}, 32'(timed_out), 0);
    check({tag, ":n_cmds"}, issued.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < issued.size()) check($sformatf("%s:cmd%0d", tag, i), 32'(issued[i]), 32'(exp_q[i]));
    check({tag, ":busy_viol"}, busy_viol, 0);
    check({tag, ":dbl_strobe"}, dbl_viol, 0);
    check({tag, ":err"}, 32'(err), 32'(exp_err));
    check({tag, ":finished"}, 32'(finished), 32'(!exp_err));
    check({tag, ":checksum"}, 32'(checksum), sum % 16384);
    check({tag, ":wr_count"}, 32'(wr_count), exp_err ? 0 : (nw > 127 ? 127 : nw));
    if (!exp_err) begin
      check({tag, ":fin_latency"}, end_cyc - done_cyc, 1);
      check({tag, ":fin_before_done"}, 32'(fin_at_done), 0);
    end else begin
      repeat (20) tick();
      check({tag, ":no_more_strobes"}, issued.size(), exp_q.size());
      check({tag, ":err_sticky"}, 32'(err), 1);
    end
  endtask

  task automatic rand_rom();
    int p;
    p = $urandom_range(0, 31);
    for (int i = 0; i < 32; i++) begin
      if (i < p) rom[i] = 4'($urandom_range(1, 15));
      else if (i == p) rom[i] = 4'd0;
      else rom[i] = 4'($urandom_range(0, 15));
    end
    for (int i = 0; i < 256; i++) wdata[i] = 8'($urandom);
    nw = $urandom_range(0, 160);
    op_len = $urandom_range(1, 5);
    init_busy = $urandom_range(0, 80);
  endtask

  initial begin
    int  ec;
    bit  to;
    int  c0;
    bit  seen;

    for (int i = 0; i < 32; i++) rom[i] = 4'd1;
    for (int i = 0; i < 256; i++) wdata[i] = 8'(i);

    // Reset held with busy high.
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst:cmd_valid", 32'(cmd_valid), 0);
      check("rst:crom_rd", 32'(CROM_rd), 0);
      check("rst:finished", 32'(finished), 0);
      check("rst:err", 32'(err), 0);
      check("rst:checksum", 32'(checksum), 0);
    end
    rst_n = 1'b1;

    // Basic run with 64 writes of D=i.
    rom[0] = 4'd5; rom[1] = 4'd1; rom[2] = 4'd7; rom[3] = 4'd0;
    init_busy = 66; op_len = 1; nw = 64;
    start_run("basic");
    wait_end(ec, to);
    check_run("basic", ec, to);
    check("basic:checksum2016", 32'(checksum), 2016);

    // Undefined code skipped.
    rom[0] = 4'd9; rom[1] = 4'd3; rom[2] = 4'd0;
    init_busy = 3; op_len = 2; nw = 10;
    start_run("skip");
    wait_end(ec, to);
    check_run("skip", ec, to);

    // Overrun: 32 valid non-WRITE entries.
    for (int i = 0; i < 32; i++) rom[i] = 4'd1;
    init_busy = 0; op_len = 1;
    start_run("overrun");
    wait_end(ec, to);
    check_run("overrun", ec, to);

    // Overrun ending on an undefined last entry.
    rom[31] = 4'd9;
    start_run("overrun_inv");
    wait_end(ec, to);
    check_run("overrun_inv", ec, to);

    // Randomized runs; run 1 gets a spurious mid-run start, run 2 a start alongside done.
    for (int r = 0; r < 6; r++) begin
      rand_rom();
      start_with_done = (r == 2);
      start_run($sformatf("rand%0d", r));
      if (r == 1) begin
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
          tick();
          seen = (issued.size() > 0);
        end
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
      end
      wait_end(ec, to);
      check_run($sformatf("rand%0d", r), ec, to);
      if (r == 2) begin
        tick();
        check("start_done:stays_fin", 32'(finished), 1);
        check("start_done:no_fetch", 32'(CROM_rd), 0);
      end
    end
    start_with_done = 1'b0;

    // Timeout in WAIT_RDY: 3 setup cycles then TIMEOUT busy cycles.
    for (int i = 0; i < 32; i++) rom[i] = 4'd2;
    rom[4] = 4'd0;
    stuck_busy = 1'b1; init_busy = 0; op_len = 1; nw = 5;
    start_run("tmo");
    c0 = cyc - 1;
    to = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (err) begin
        to = 1'b0;
        break;
      end
    end
    check("tmo:expired", 32'(to), 0);
    check("tmo:cycles", cyc - c0, 1026);
    check("tmo:no_strobe", issued.size(), 0);
    stuck_busy = 1'b0;
    start_run("tmo_restart");
    wait_end(ec, to);
    check_run("tmo_restart", ec, to);

    // Asynchronous reset during the write phase.
    rom[0] = 4'd2; rom[1] = 4'd0;
    for (int i = 0; i < 256; i++) wdata[i] = 8'($urandom_range(1, 255));
    nw = 100; init_busy = 2;
    start_run("midrst");
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      tick();
      seen = (checksum != 0);
    end
    check("midrst:snoop_active", 32'(seen), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst:cmd_valid", 32'(cmd_valid), 0);
    check("midrst:crom_rd", 32'(CROM_rd), 0);
    check("midrst:checksum", 32'(checksum), 0);
    check("midrst:wr_count", 32'(wr_count), 0);
    check("midrst:finished", 32'(finished), 0);
    tick();
    rst_n = 1'b1;

    rand_rom();
    start_run("post_rst");
    wait_end(ec, to);
    check_run("post_rst", ec, to);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
